// File: rtl/i2c_target.sv
// I2C target with a fixed 7-bit address: input synchronizer/glitch filter, START/STOP
// detection, address match with ACK, write-byte reception and read-byte transmission.
//
// state    | meaning
// IDLE     | not selected, waiting for START
// ADDR     | shifting in the address byte
// ADDR_ACK | driving ACK for a matched address
// RX       | shifting in a write byte
// RX_ACK   | driving ACK for a received byte
// TX       | shifting out a read byte
// TX_ACK   | SDA released, waiting for the master's ACK/NACK
module i2c_target #(
  parameter logic [6:0] ADDRESS    = 7'h3C,
  parameter int         FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_pull_low,
  output logic       addressed,
  output logic       rw,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_load,
  output logic       nack_seen,
  output logic       start_seen,
  output logic       stop_seen
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_RX, ST_RX_ACK, ST_TX, ST_TX_ACK
  } state_t;

  // Bit 1 carries SCL, bit 0 carries SDA; all reset to the idle-bus level.
  logic [1:0]    r_sync1, r_sync2, r_filt, r_filt_q;
  logic [CW-1:0] r_fcnt [2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1  <= 2'b11;
      r_sync2  <= 2'b11;
      r_filt   <= 2'b11;
      r_filt_q <= 2'b11;
      for (int i = 0; i < 2; i++) r_fcnt[i] <= '0;
    end else begin
      r_sync1  <= {scl_in, sda_in};
      r_sync2  <= r_sync1;
      r_filt_q <= r_filt;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_filt[i]) begin
          r_fcnt[i] <= '0;
        end else if (r_fcnt[i] == CW'(FILTER_LEN - 1)) begin
          r_filt[i] <= r_sync2[i];
          r_fcnt[i] <= '0;
        end else begin
          r_fcnt[i] <= r_fcnt[i] + CW'(1);
        end
      end
    end
  end

  logic w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
  assign w_sda      = r_filt[0];
  assign w_scl_rise = r_filt[1] & ~r_filt_q[1];
  assign w_scl_fall = ~r_filt[1] & r_filt_q[1];
  // SCL must be high in both samples so a simultaneous SCL/SDA edge is not a bus condition.
  assign w_start    = r_filt[1] & r_filt_q[1] & r_filt_q[0] & ~r_filt[0];
  assign w_stop     = r_filt[1] & r_filt_q[1] & ~r_filt_q[0] & r_filt[0];

  state_t     r_state, w_state_n;
  logic [7:0] r_shift, w_shift_n;
  logic [3:0] r_cnt, w_cnt_n;
  logic [7:0] w_rx_data_n;
  logic       w_pull_n, w_addr_n, w_rw_n, w_rx_valid_n, w_nack_n, w_start_n, w_stop_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_shift      <= '0;
      r_cnt        <= '0;
      sda_pull_low <= 1'b0;
      addressed    <= 1'b0;
      rw           <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      nack_seen    <= 1'b0;
      start_seen   <= 1'b0;
      stop_seen    <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_shift      <= w_shift_n;
      r_cnt        <= w_cnt_n;
      sda_pull_low <= w_pull_n;
      addressed    <= w_addr_n;
      rw           <= w_rw_n;
      rx_data      <= w_rx_data_n;
      rx_valid     <= w_rx_valid_n;
      nack_seen    <= w_nack_n;
      start_seen   <= w_start_n;
      stop_seen    <= w_stop_n;
    end
  end

  always_comb begin
    w_state_n    = r_state;
    w_shift_n    = r_shift;
    w_cnt_n      = r_cnt;
    w_pull_n     = sda_pull_low;
    w_addr_n     = addressed;
    w_rw_n       = rw;
    w_rx_data_n  = rx_data;
    w_rx_valid_n = 1'b0;
    w_nack_n     = 1'b0;
    w_start_n    = 1'b0;
    w_stop_n     = 1'b0;
    tx_load      = 1'b0;
    if (w_start) begin
      w_state_n = ST_ADDR;
      w_cnt_n   = '0;
      w_pull_n  = 1'b0;
      w_addr_n  = 1'b0;
      w_start_n = 1'b1;
    end else if (w_stop) begin
      w_state_n = ST_IDLE;
      w_pull_n  = 1'b0;
      w_addr_n  = 1'b0;
      w_stop_n  = 1'b1;
    end else begin
      case (r_state)
        ST_ADDR, ST_RX: begin
          if (w_scl_rise && r_cnt != 4'd8) begin
            w_shift_n = {r_shift[6:0], w_sda};
            w_cnt_n   = r_cnt + 4'd1;
          end else if (w_scl_fall && r_cnt == 4'd8) begin
            w_cnt_n = '0;
            if (r_state == ST_RX) begin
              w_rx_data_n  = r_shift;
              w_rx_valid_n = 1'b1;
              w_pull_n     = 1'b1;
              w_state_n    = ST_RX_ACK;
            end else if (r_shift[7:1] == ADDRESS) begin
              w_rw_n    = r_shift[0];
              w_addr_n  = 1'b1;
              w_pull_n  = 1'b1;
              w_state_n = ST_ADDR_ACK;
            end else begin
              w_pull_n  = 1'b0;
              w_state_n = ST_IDLE;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (w_scl_fall) begin
            w_cnt_n = '0;
            if (rw) begin
              tx_load   = 1'b1;
              w_shift_n = tx_data;
              w_pull_n  = ~tx_data[7];
              w_state_n = ST_TX;
            end else begin
              w_pull_n  = 1'b0;
              w_state_n = ST_RX;
            end
          end
        end
        ST_RX_ACK: begin
          if (w_scl_fall) begin
            w_pull_n  = 1'b0;
            w_cnt_n   = '0;
            w_state_n = ST_RX;
          end
        end
        ST_TX: begin
          if (w_scl_rise && r_cnt != 4'd8) begin
            w_cnt_n = r_cnt + 4'd1;
          end else if (w_scl_fall && r_cnt == 4'd8) begin
            w_pull_n  = 1'b0;
            w_cnt_n   = '0;
            w_state_n = ST_TX_ACK;
          end else if (w_scl_fall && r_cnt != 4'd0) begin
            w_shift_n = {r_shift[6:0], 1'b0};
            w_pull_n  = ~r_shift[6];
          end
        end
        ST_TX_ACK: begin
          // r_cnt marks that an ACK was sampled and the next byte is due at the fall.
          if (w_scl_rise && r_cnt == 4'd0) begin
            if (w_sda) begin
              w_nack_n  = 1'b1;
              w_addr_n  = 1'b0;
              w_pull_n  = 1'b0;
              w_state_n = ST_IDLE;
            end else begin
              w_cnt_n = 4'd1;
            end
          end else if (w_scl_fall && r_cnt == 4'd1) begin
            tx_load   = 1'b1;
            w_shift_n = tx_data;
            w_pull_n  = ~tx_data[7];
            w_cnt_n   = '0;
            w_state_n = ST_TX;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-level I2C master model drives the bus and a
// scoreboard queue holds the bytes the target is expected to report or transmit.
module tb_i2c_target;
  localparam int Q = 20;  // clk cycles per quarter SCL period

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       sda_line;
  logic       sda_pull_low, addressed, rw, rx_valid, tx_load, nack_seen, start_seen, stop_seen;
  logic [7:0] rx_data;

  assign sda_line = m_sda & ~sda_pull_low;

  i2c_target #(.ADDRESS(7'h3C), .FILTER_LEN(3)) dut (
    .clk(clk), .reset(reset), .scl_in(m_scl), .sda_in(sda_line),
    .sda_pull_low(sda_pull_low), .addressed(addressed), .rw(rw),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_load(tx_load),
    .nack_seen(nack_seen), .start_seen(start_seen), .stop_seen(stop_seen)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_start = 0, n_stop = 0, n_rx = 0, n_load = 0, n_nack = 0;
  logic [7:0] rx_exp[$];
  logic [7:0] tx_exp[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (start_seen) n_start++;
      if (tx_load) n_load++;
      if (nack_seen) n_nack++;
      if (stop_seen) begin
        n_stop++;
        chk("addressed_at_stop", addressed, 0);
      end
      if (rx_valid) begin
        n_rx++;
        chk("rx_expected_pending", rx_exp.size() != 0, 1);
        if (rx_exp.size() != 0) chk("rx_data", rx_data, rx_exp.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic do_start();
    wq(); m_sda = 1'b0; wq(); m_scl = 1'b0;
  endtask

  task automatic do_rstart();
    wq(); m_sda = 1'b1; wq(); m_scl = 1'b1; wq(); m_sda = 1'b0; wq(); m_scl = 1'b0;
  endtask

  task automatic do_stop();
    wq(); m_sda = 1'b0; wq(); m_scl = 1'b1; wq(); m_sda = 1'b1; wq(); wq();
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      wq(); m_sda = b[i]; wq(); m_scl = 1'b1; wq(); wq(); m_scl = 1'b0;
    end
  endtask

  // Returns the target's SDA drive sampled mid-high of the 9th clock.
  task automatic write_byte(input logic [7:0] b, output logic pull);
    send_bits(b, 8);
    wq(); m_sda = 1'b1; wq(); m_scl = 1'b1; wq(); pull = sda_pull_low; wq(); m_scl = 1'b0;
  endtask

  task automatic read_byte(input logic ack_bit, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      wq(); m_sda = 1'b1; wq(); m_scl = 1'b1; wq(); b[i] = sda_line; wq(); m_scl = 1'b0;
    end
    wq(); m_sda = ack_bit; wq(); m_scl = 1'b1; wq(); wq(); m_scl = 1'b0;
  endtask

  initial begin
    logic       pull;
    logic [7:0] rb;
    int         s0, p0, r0, l0, k0;

    repeat (3) @(negedge clk);
    chk("reset_outputs", {sda_pull_low, addressed, rw, rx_data, rx_valid, tx_load,
                          nack_seen, start_seen, stop_seen}, 0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // 1: write 0xA5
    s0 = n_start; p0 = n_stop; r0 = n_rx;
    do_start();
    write_byte(8'h78, pull);
    chk("t1_addr_ack", pull, 1);
    chk("t1_rw", rw, 0);
    chk("t1_addressed", addressed, 1);
    rx_exp.push_back(8'hA5);
    write_byte(8'hA5, pull);
    chk("t1_data_ack", pull, 1);
    do_stop();
    chk("t1_rx_count", n_rx, r0 + 1);
    chk("t1_start_count", n_start, s0 + 1);
    chk("t1_stop_count", n_stop, p0 + 1);
    chk("t1_addressed_after", addressed, 0);

    // 2: foreign address, then a byte that must not be reported
    r0 = n_rx;
    do_start();
    write_byte(8'hA0, pull);
    chk("t2_no_ack", pull, 0);
    chk("t2_addressed", addressed, 0);
    write_byte(8'h55, pull);
    chk("t2_no_data_ack", pull, 0);
    do_stop();
    chk("t2_rx_count", n_rx, r0);

    // 3: read two bytes, ACK then NACK
    l0 = n_load; k0 = n_nack;
    tx_data = 8'h5A;
    tx_exp.push_back(8'h5A);
    tx_exp.push_back(8'hA5);
    do_start();
    write_byte(8'h79, pull);
    chk("t3_addr_ack", pull, 1);
    chk("t3_rw", rw, 1);
    read_byte(1'b0, rb);
    chk("t3_byte0", rb, tx_exp.pop_front());
    tx_data = 8'hA5;
    read_byte(1'b1, rb);
    chk("t3_byte1", rb, tx_exp.pop_front());
    repeat (20) @(negedge clk);
    chk("t3_tx_load_count", n_load, l0 + 2);
    chk("t3_nack_count", n_nack, k0 + 1);
    chk("t3_addressed_after", addressed, 0);
    chk("t3_sda_released", sda_pull_low, 0);
    do_stop();

    // 4: repeated START mid-byte discards the partial byte
    s0 = n_start; r0 = n_rx;
    do_start();
    write_byte(8'h78, pull);
    chk("t4_addr_ack", pull, 1);
    send_bits(8'hA0, 4);
    do_rstart();
    write_byte(8'h78, pull);
    chk("t4_addr2_ack", pull, 1);
    rx_exp.push_back(8'h3C);
    write_byte(8'h3C, pull);
    chk("t4_data_ack", pull, 1);
    do_stop();
    chk("t4_start_count", n_start, s0 + 2);
    chk("t4_rx_count", n_rx, r0 + 1);

    // 5: one-cycle SDA glitch with SCL high
    s0 = n_start; p0 = n_stop;
    @(negedge clk); m_sda = 1'b0;
    @(negedge clk); m_sda = 1'b1;
    repeat (20) @(negedge clk);
    chk("t5_start_count", n_start, s0);
    chk("t5_stop_count", n_stop, p0);
    chk("t5_addressed", addressed, 0);

    // 6: async reset during the address ACK, then a clean transfer
    do_start();
    send_bits(8'h78, 8);
    wq();
    chk("t6_ack_driven", sda_pull_low, 1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t6_sda_released_async", sda_pull_low, 0);
    chk("t6_outputs", {sda_pull_low, addressed, rw, rx_data, rx_valid, tx_load,
                       nack_seen, start_seen, stop_seen}, 0);
    m_scl = 1'b1; m_sda = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    r0 = n_rx;
    do_start();
    write_byte(8'h78, pull);
    chk("t6_addr_ack", pull, 1);
    rx_exp.push_back(8'hC3);
    write_byte(8'hC3, pull);
    chk("t6_data_ack", pull, 1);
    do_stop();
    chk("t6_rx_count", n_rx, r0 + 1);
    chk("rx_queue_drained", rx_exp.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
